// File: rtl/btb_predictor_sa.sv
`default_nettype none
// ============================================================================
// Module  : btb_predictor_sa
// Brief   : Set-associative, warp-hashed branch target buffer with 2-bit
//           direction counters, round-robin replacement and a sequential flush.
// Revision: 1.0 - initial release
// ============================================================================
module btb_predictor_sa #(
    parameter int PC_W   = 32,
    parameter int N_SETS = 64,
    parameter int WAYS   = 2,
    parameter int OFFSET = 4,
    parameter int WARP_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [WARP_W-1:0] rd_warp,
    input  logic [PC_W-1:0]   rd_pc,
    output logic              pr_valid,
    output logic              pr_hit,
    output logic              pr_taken,
    output logic [PC_W-1:0]   pr_target,
    output logic [WARP_W-1:0] pr_warp,
    input  logic              upd_valid,
    input  logic [WARP_W-1:0] upd_warp,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              flush,
    output logic              busy
);

    localparam int IDX_W = $clog2(N_SETS);
    localparam int TAG_W = PC_W - IDX_W - OFFSET;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WX_W  = (WARP_W < IDX_W) ? WARP_W : IDX_W;
    localparam logic [IDX_W-1:0] c_last_set = IDX_W'(N_SETS - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_fcnt;
    logic               r_valid [N_SETS][WAYS];
    logic [TAG_W-1:0]   r_tag   [N_SETS][WAYS];
    logic [1:0]         r_ctr   [N_SETS][WAYS];
    logic [PC_W-1:0]    r_tgt   [N_SETS][WAYS];
    logic [PTR_W-1:0]   r_ptr   [N_SETS];

    logic               r_pr_valid, r_pr_hit, r_pr_taken;
    logic [PC_W-1:0]    r_pr_target;
    logic [WARP_W-1:0]  r_pr_warp;

    logic [IDX_W-1:0]   w_u_idx, w_r_idx;
    logic [TAG_W-1:0]   w_u_tag, w_r_tag;
    logic               w_upd_go, w_acc, w_fwd;
    logic               w_u_hit, w_u_inv, w_u_we;
    logic [PTR_W-1:0]   w_u_hway, w_u_iway, w_u_vic;
    logic               w_nv_valid [WAYS];
    logic [TAG_W-1:0]   w_nv_tag   [WAYS];
    logic [1:0]         w_nv_ctr   [WAYS];
    logic [PC_W-1:0]    w_nv_tgt   [WAYS];
    logic [PTR_W-1:0]   w_nv_ptr;
    logic               w_l_hit, w_l_taken;
    logic [PC_W-1:0]    w_l_target;
    logic               w_unused_bits;

    // Warp id is zero-extended (or truncated) to the index width, then XORed in.
    assign w_u_idx  = upd_pc[OFFSET +: IDX_W] ^ IDX_W'(upd_warp[WX_W-1:0]);
    assign w_r_idx  = rd_pc[OFFSET +: IDX_W]  ^ IDX_W'(rd_warp[WX_W-1:0]);
    assign w_u_tag  = upd_pc[OFFSET+IDX_W +: TAG_W];
    assign w_r_tag  = rd_pc[OFFSET+IDX_W +: TAG_W];
    assign w_unused_bits = ^{rd_pc[OFFSET-1:0], upd_pc[OFFSET-1:0]};

    assign rd_ready = (r_state == ST_IDLE);
    assign busy     = (r_state == ST_FLUSH);
    assign w_upd_go = upd_valid && (r_state == ST_IDLE);
    assign w_acc    = rd_valid && rd_ready;
    assign w_fwd    = w_upd_go && (w_u_idx == w_r_idx);

    // Post-update contents of the set addressed by the update.
    always_comb begin
        w_u_hit  = 1'b0;
        w_u_hway = '0;
        w_u_inv  = 1'b0;
        w_u_iway = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_u_idx][w] && (r_tag[w_u_idx][w] == w_u_tag)) begin
                w_u_hit  = 1'b1;
                w_u_hway = PTR_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_u_idx][w]) begin
                w_u_inv  = 1'b1;
                w_u_iway = PTR_W'(w);
            end
        end
        w_u_vic  = w_u_inv ? w_u_iway : r_ptr[w_u_idx];
        w_u_we   = w_upd_go && (w_u_hit || upd_taken);
        w_nv_ptr = r_ptr[w_u_idx];
        if (w_upd_go && !w_u_hit && upd_taken && !w_u_inv)
            w_nv_ptr = (WAYS == 1) ? '0 : r_ptr[w_u_idx] + PTR_W'(1);
        for (int w = 0; w < WAYS; w++) begin
            w_nv_valid[w] = r_valid[w_u_idx][w];
            w_nv_tag[w]   = r_tag[w_u_idx][w];
            w_nv_ctr[w]   = r_ctr[w_u_idx][w];
            w_nv_tgt[w]   = r_tgt[w_u_idx][w];
            if (w_upd_go && w_u_hit && (w_u_hway == PTR_W'(w))) begin
                if (upd_taken) begin
                    if (r_ctr[w_u_idx][w] != 2'd3)
                        w_nv_ctr[w] = r_ctr[w_u_idx][w] + 2'd1;
                    w_nv_tgt[w] = upd_target;
                end else if (r_ctr[w_u_idx][w] != 2'd0) begin
                    w_nv_ctr[w] = r_ctr[w_u_idx][w] - 2'd1;
                end
            end
            if (w_upd_go && !w_u_hit && upd_taken && (w_u_vic == PTR_W'(w))) begin
                w_nv_valid[w] = 1'b1;
                w_nv_tag[w]   = w_u_tag;
                w_nv_ctr[w]   = 2'b10;
                w_nv_tgt[w]   = upd_target;
            end
        end
    end

    // Lookup reads the post-update view when the update hits the same set.
    always_comb begin
        w_l_hit    = 1'b0;
        w_l_taken  = 1'b0;
        w_l_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_fwd) begin
                if (w_nv_valid[w] && (w_nv_tag[w] == w_r_tag)) begin
                    w_l_hit    = 1'b1;
                    w_l_taken  = w_nv_ctr[w][1];
                    w_l_target = w_nv_tgt[w];
                end
            end else if (r_valid[w_r_idx][w] && (r_tag[w_r_idx][w] == w_r_tag)) begin
                w_l_hit    = 1'b1;
                w_l_taken  = r_ctr[w_r_idx][w][1];
                w_l_target = r_tgt[w_r_idx][w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_ctr[s][w]   <= 2'b01;
                end
                r_ptr[s] <= '0;
            end
            r_state     <= ST_IDLE;
            r_fcnt      <= '0;
            r_pr_valid  <= 1'b0;
            r_pr_hit    <= 1'b0;
            r_pr_taken  <= 1'b0;
            r_pr_target <= '0;
            r_pr_warp   <= '0;
        end else begin
            r_pr_valid  <= w_acc;
            r_pr_hit    <= w_acc && w_l_hit;
            r_pr_taken  <= w_acc && w_l_taken;
            r_pr_target <= w_acc ? w_l_target : '0;
            r_pr_warp   <= w_acc ? rd_warp : '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_u_we) begin
                        for (int w = 0; w < WAYS; w++) begin
                            r_valid[w_u_idx][w] <= w_nv_valid[w];
                            r_tag[w_u_idx][w]   <= w_nv_tag[w];
                            r_ctr[w_u_idx][w]   <= w_nv_ctr[w];
                            r_tgt[w_u_idx][w]   <= w_nv_tgt[w];
                        end
                        r_ptr[w_u_idx] <= w_nv_ptr;
                    end
                    if (flush) begin
                        r_state <= ST_FLUSH;
                        r_fcnt  <= '0;
                    end
                end
                ST_FLUSH: begin
                    for (int w = 0; w < WAYS; w++)
                        r_valid[r_fcnt][w] <= 1'b0;
                    r_ptr[r_fcnt] <= '0;
                    r_fcnt        <= r_fcnt + IDX_W'(1);
                    if (r_fcnt == c_last_set)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pr_valid  = r_pr_valid;
    assign pr_hit    = r_pr_hit;
    assign pr_taken  = r_pr_taken;
    assign pr_target = r_pr_target;
    assign pr_warp   = r_pr_warp;

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor_sa.sv
`default_nettype none
// ============================================================================
// Module  : tb_btb_predictor_sa
// Brief   : Scoreboard bench for btb_predictor_sa against an array-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_btb_predictor_sa;

    localparam int N_SETS = 64;
    localparam int WAYS   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_valid = 1'b0, rd_ready;
    logic [4:0]  rd_warp = '0;
    logic [31:0] rd_pc = '0;
    logic        pr_valid, pr_hit, pr_taken;
    logic [31:0] pr_target;
    logic [4:0]  pr_warp;
    logic        upd_valid = 1'b0, upd_taken = 1'b0;
    logic [4:0]  upd_warp = '0;
    logic [31:0] upd_pc = '0, upd_target = '0;
    logic        flush = 1'b0, busy;

    btb_predictor_sa dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_warp(rd_warp), .rd_pc(rd_pc),
        .pr_valid(pr_valid), .pr_hit(pr_hit), .pr_taken(pr_taken),
        .pr_target(pr_target), .pr_warp(pr_warp),
        .upd_valid(upd_valid), .upd_warp(upd_warp), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [4:0]  warp;
    } pred_t;

    pred_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 1'b0;

    // Reference model: plain arrays holding the architectural BTB contents.
    bit          m_valid [N_SETS][WAYS];
    bit [21:0]   m_tag   [N_SETS][WAYS];
    int          m_ctr   [N_SETS][WAYS];
    bit [31:0]   m_tgt   [N_SETS][WAYS];
    int          m_ptr   [N_SETS];
    int          m_busy  = 0;

    function automatic int m_idx(bit [4:0] warp, bit [31:0] pc);
        return ((pc >> 4) % N_SETS) ^ int'(warp);
    endfunction

    function automatic bit [21:0] m_tagf(bit [31:0] pc);
        bit [31:0] t;
        t = pc >> 10;
        return t[21:0];
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < N_SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_ctr[s][w]   = 1;
            end
            m_ptr[s] = 0;
        end
        m_busy = 0;
    endfunction

    function automatic void m_update(bit [4:0] warp, bit [31:0] pc, bit taken, bit [31:0] tgt);
        int s, hw, v;
        s  = m_idx(warp, pc);
        hw = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == m_tagf(pc)) hw = w;
        if (hw >= 0) begin
            if (taken) begin
                m_ctr[s][hw] = (m_ctr[s][hw] == 3) ? 3 : m_ctr[s][hw] + 1;
                m_tgt[s][hw] = tgt;
            end else begin
                m_ctr[s][hw] = (m_ctr[s][hw] == 0) ? 0 : m_ctr[s][hw] - 1;
            end
        end else if (taken) begin
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (!m_valid[s][w] && v < 0) v = w;
            if (v < 0) begin
                v = m_ptr[s];
                m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = m_tagf(pc);
            m_ctr[s][v]   = 2;
            m_tgt[s][v]   = tgt;
        end
    endfunction

    function automatic pred_t m_lookup(bit [4:0] warp, bit [31:0] pc);
        pred_t p;
        int s;
        s = m_idx(warp, pc);
        p = '{hit: 1'b0, taken: 1'b0, target: 32'd0, warp: warp};
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == m_tagf(pc)) begin
                p.hit    = 1'b1;
                p.taken  = (m_ctr[s][w] >= 2);
                p.target = m_tgt[s][w];
            end
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle either an expected prediction is popped or pr_valid must be low.
    always @(negedge clk) begin : mon
        pred_t e;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pr_valid", {31'd0, pr_valid}, 32'd1);
                chk("pr_hit", {31'd0, pr_hit}, {31'd0, e.hit});
                chk("pr_taken", {31'd0, pr_taken}, {31'd0, e.taken});
                chk("pr_target", pr_target, e.target);
                chk("pr_warp", {27'd0, pr_warp}, {27'd0, e.warp});
            end else begin
                chk("pr_valid_idle", {31'd0, pr_valid}, 32'd0);
            end
        end
    end

    task automatic step(input logic rv, input logic [4:0] rw, input logic [31:0] rp,
                        input logic uv, input logic [4:0] uw, input logic [31:0] up,
                        input logic ut, input logic [31:0] utg, input logic fl);
        rd_valid = rv;  rd_warp = rw;  rd_pc = rp;
        upd_valid = uv; upd_warp = uw; upd_pc = up; upd_taken = ut; upd_target = utg;
        flush = fl;
        chk("busy", {31'd0, busy}, {31'd0, (m_busy != 0)});
        chk("rd_ready", {31'd0, rd_ready}, {31'd0, (m_busy == 0)});
        @(posedge clk);
        if (m_busy > 0) begin
            m_busy--;
        end else begin
            if (uv) m_update(uw, up, ut, utg);
            if (rv) exp_q.push_back(m_lookup(rw, rp));
            if (fl) begin
                for (int s = 0; s < N_SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
                    m_ptr[s] = 0;
                end
                m_busy = N_SETS;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic lookup(input logic [4:0] w, input logic [31:0] pc);
        step(1'b1, w, pc, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic update(input logic [4:0] w, input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(1'b0, 5'd0, 32'd0, 1'b1, w, pc, t, tg, 1'b0);
    endtask

    task automatic do_reset(input bit noisy);
        rst = 1'b1;
        rd_valid = noisy; upd_valid = noisy; upd_taken = noisy; flush = noisy;
        upd_pc = 32'h100; rd_pc = 32'h100;
        @(posedge clk);
        m_reset();
        exp_q.delete();
        #1;
        rst = 1'b0;
        rd_valid = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0; flush = 1'b0;
        chk("rst_pr_valid", {31'd0, pr_valid}, 32'd0);
        chk("rst_pr_hit", {31'd0, pr_hit}, 32'd0);
        chk("rst_pr_taken", {31'd0, pr_taken}, 32'd0);
        chk("rst_pr_target", pr_target, 32'd0);
        chk("rst_pr_warp", {27'd0, pr_warp}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_pc();
        return (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
               | 32'($urandom_range(0, 15));
    endfunction

    initial begin
        do_reset(1'b0);
        mon_en = 1'b1;

        // Cold miss, allocate and train.
        lookup(5'd0, 32'h100);
        update(5'd0, 32'h100, 1'b1, 32'h400);
        lookup(5'd0, 32'h100);
        update(5'd0, 32'h100, 1'b0, 32'h0);
        update(5'd0, 32'h100, 1'b0, 32'h0);
        lookup(5'd0, 32'h100);

        // Replacement within set 0x10 and warp hashing.
        do_reset(1'b0);
        update(5'd0, 32'h100, 1'b1, 32'h1100);
        update(5'd0, 32'h500, 1'b1, 32'h1500);
        update(5'd0, 32'h900, 1'b1, 32'h1900);
        lookup(5'd0, 32'h100);
        lookup(5'd0, 32'h500);
        lookup(5'd0, 32'h900);
        lookup(5'd1, 32'h900);
        update(5'd0, 32'h100, 1'b1, 32'h2100);
        lookup(5'd1, 32'h100);
        lookup(5'd0, 32'h100);

        // Flush: busy window, ignored update, then everything misses.
        update(5'd0, 32'h200, 1'b1, 32'h3000);
        update(5'd3, 32'h340, 1'b1, 32'h3100);
        step(1'b1, 5'd0, 32'h200, 1'b1, 5'd2, 32'h7f0, 1'b1, 32'h3200, 1'b1);
        for (int i = 0; i < N_SETS; i++)
            step(1'b1, 5'd0, 32'h200, (i == 5), 5'd0, 32'h600, 1'b1, 32'h3300, (i == 7));
        lookup(5'd0, 32'h200);
        lookup(5'd3, 32'h340);
        lookup(5'd2, 32'h7f0);
        lookup(5'd0, 32'h600);
        lookup(5'd0, 32'h900);

        // Same-cycle forwarding, then reset in the middle of a flush.
        step(1'b1, 5'd0, 32'h200, 1'b1, 5'd0, 32'h200, 1'b1, 32'h800, 1'b0);
        step(1'b1, 5'd0, 32'h200, 1'b1, 5'd0, 32'h200, 1'b0, 32'h0, 1'b0);
        update(5'd4, 32'hc40, 1'b1, 32'h900);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) idle();
        do_reset(1'b1);
        lookup(5'd0, 32'h200);
        lookup(5'd4, 32'hc40);
        lookup(5'd0, 32'h100);

        // Randomized traffic over a small address pool to exercise aliasing and eviction.
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 499);
            if (r == 0)
                do_reset(1'b1);
            else
                step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 3)), rnd_pc(),
                     ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)), rnd_pc(),
                     ($urandom_range(0, 2) != 0), $urandom(), (r < 3));
        end

        idle();
        idle();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
